// File: rtl/i2s_frame_scheduler.sv
// i2s_frame_scheduler: buffers stereo pairs and presents one pair per I2S frame,
// updated at frame count 0 so the driver's load edge always sees stable data.
module i2s_frame_scheduler #(
    parameter int BUS_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int PRIME_LEVEL = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          mute,
    input  logic                          clr_stat,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [BUS_WIDTH-1:0]          s_l,
    input  logic [BUS_WIDTH-1:0]          s_r,
    output logic [BUS_WIDTH-1:0]          data_l,
    output logic [BUS_WIDTH-1:0]          data_r,
    output logic                          frame_tick,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [1:0]                    state,
    output logic                          underrun,
    output logic [CNT_WIDTH-1:0]          underrun_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = $clog2(2 * BUS_WIDTH + 2);
    localparam logic [FW-1:0] LAST     = FW'(2 * BUS_WIDTH + 1);
    localparam logic [LW-1:0] PRIME_LV = LW'(PRIME_LEVEL);
    localparam logic [LW-1:0] DEPTH_LV = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, UNDER} state_t;

    state_t                 state_q, state_d;
    logic [FW-1:0]          frame_q, frame_d;
    logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   s_ready_q, s_ready_d;
    logic [BUS_WIDTH-1:0]   data_l_q, data_l_d, data_r_q, data_r_d;
    logic                   underrun_q, underrun_d;
    logic [CNT_WIDTH-1:0]   ucnt_q, ucnt_d;
    logic [2*BUS_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                   pop_pt, push, pop, inc;

    always_comb begin
        pop_pt     = frame_q == '0;
        push       = en & s_valid & s_ready_q;
        pop        = en & pop_pt & (state_q == RUN) & (level_q != '0);
        // underrun frames: empty in RUN, or still below prime level after an underrun
        inc        = en & pop_pt & (level_q < PRIME_LV) &
                     ((state_q == RUN && level_q == '0) || state_q == UNDER);
        frame_d    = frame_q == LAST ? '0 : frame_q + 1'b1;
        wr_d       = !en ? '0 : push ? wr_q + 1'b1 : wr_q;
        rd_d       = !en ? '0 : pop ? rd_q + 1'b1 : rd_q;
        level_d    = !en ? '0 : level_q + LW'(push) - LW'(pop);
        s_ready_d  = en & (level_d != DEPTH_LV);
        state_d    = !en ? IDLE :
                     state_q == IDLE ? PRIME :
                     (state_q == PRIME || state_q == UNDER) && level_q >= PRIME_LV ? RUN :
                     state_q == RUN && pop_pt && level_q == '0 ? UNDER : state_q;
        {data_l_d, data_r_d} = !en ? '0 :
                               pop ? (mute ? '0 : mem_q[rd_q]) :
                               pop_pt ? '0 : {data_l_q, data_r_q};
        underrun_d = !clr_stat & (underrun_q | inc);
        ucnt_d     = clr_stat ? '0 : (inc && ucnt_q != '1) ? ucnt_q + 1'b1 : ucnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            level_q    <= '0;
            s_ready_q  <= 1'b0;
            data_l_q   <= '0;
            data_r_q   <= '0;
            underrun_q <= 1'b0;
            ucnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            level_q    <= level_d;
            s_ready_q  <= s_ready_d;
            data_l_q   <= data_l_d;
            data_r_q   <= data_r_d;
            underrun_q <= underrun_d;
            ucnt_q     <= ucnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {s_l, s_r};
    end

    assign s_ready      = s_ready_q;
    assign data_l       = data_l_q;
    assign data_r       = data_r_q;
    assign frame_tick   = frame_q == LAST;
    assign level        = level_q;
    assign state        = state_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;
endmodule
